sig_cfg_ctrl: RTL
=================

// Module: sig_cfg_ctrl
// PURPOSE
//  Menu/configuration controller for the signal-generator path. Consumes debounced one-cycle
//  button release pulses and walks the TOP -> SIG/OSI/LoA menu. Holds editable shadow copies of
//  wave/amp/fre/phase selections and commits them to the sig_gen datapath via a valid/ready
//  handshake. Gates generation with run_en. Sits between the buttopn_debounde instances and
//  sig_gen/hdmi_dis.
// PARAMETERS
//  N_TOP      3  number of top-menu entries (0=SIG, 1=OSI, 2=LoA)
//  N_ROWS     5  SIG menu rows: 0=wave, 1=amp, 2=fre, 3=phase/duty, 4=apply
//  FIELD_MAX  3  max value of each 2-bit field; fields wrap 0..FIELD_MAX
// PORTS
//  clk_50M      in   1  system clock, all logic on rising edge
//  rst_n        in   1  asynchronous active-low reset
//  btn_left     in   1  one-cycle pulse, decrement selection
//  btn_right    in   1  one-cycle pulse, increment selection
//  btn_up       in   1  one-cycle pulse, previous row
//  btn_down     in   1  one-cycle pulse, next row
//  btn_confirm  in   1  one-cycle pulse, enter/apply
//  btn_quit     in   1  one-cycle pulse, back to TOP
//  cfg_ready    in   1  datapath accepts cfg_word when high with cfg_valid
//  menu_state   out  3  0=TOP 1=SIG_EDIT 2=SIG_WAIT 3=SIG_RUN 4=OSI 5=LOA
//  level        out  1  1 when menu_state != TOP (display hierarchy)
//  top_sel      out  2  highlighted top entry
//  row_sel      out  3  highlighted SIG row
//  shadow_cfg   out  8  {wave,amp,fre,phase} being edited (display)
//  cfg_valid    out  1  commit request
//  cfg_word     out  8  {wave,amp,fre,phase} offered; stable while cfg_valid=1
//  run_en       out  1  datapath enable; last committed config is active
// BEHAVIOUR
//  - All outputs registered. On rst_n low (any time, incl. mid-handshake), all regs and outputs
//    go to 0 and the state to TOP.
//  - Per-cycle button priority: quit > confirm > up/down > left/right. Only the highest-priority
//    pulse acts; the rest are dropped. up and down together: up wins. left and right together:
//    left wins.
//  - TOP: left/right wrap top_sel over 0..N_TOP-1. confirm with sel 0/1/2 -> SIG_EDIT/OSI/LOA.
//    quit has no effect.
//  - SIG_EDIT: up/down wrap row_sel over 0..N_ROWS-1. left/right wrap the field addressed by
//    row_sel (rows 0-3); no effect on row 4. confirm on row 4 -> SIG_WAIT, and next cycle
//    cfg_valid=1 with cfg_word=shadow_cfg. confirm on rows 0-3 is ignored.
//  - SIG_WAIT:
//    - cfg_valid and cfg_word held. left/right/up/down/confirm ignored.
//    - Transfer occurs in the cycle where cfg_valid & cfg_ready. Next cycle: cfg_valid=0,
//      run_en=1, state SIG_RUN.
//    - No timeout; waiting is indefinite.
//  - SIG_RUN:
//    - run_en=1. Shadow edits and row moves are allowed as in SIG_EDIT; they do not alter
//      cfg_word.
//    - confirm on row 4 -> SIG_WAIT, with run_en kept at 1 so the old config runs until the
//      new one transfers.
//  - OSI, LOA: placeholders; only quit acts (-> TOP).
//  - quit in any non-TOP state:
//    - Next cycle: state TOP, run_en=0, cfg_valid=0.
//    - row_sel, top_sel and shadow_cfg reset to 0. cfg_word keeps its last value.
//    - If cfg_ready is high in the same cycle as quit in SIG_WAIT, the transfer counts, but
//      quit still wins: state TOP, run_en=0.
//  - Latency: button pulse -> register/output update is exactly 1 cycle.
//    confirm(row 4) -> cfg_valid is 1 cycle. ready -> run_en is 1 cycle.
// TESTING
//  1 Reset: rst_n low mid-SIG_WAIT -> all outputs 0 asynchronously, menu_state=0 after release.
//  2 Wrap: TOP, left x1 -> top_sel=2; right x1 -> 0. SIG_EDIT up at row 0 -> row_sel=4.
//  3 Commit: set wave=2, amp=1, fre=3, phase=0, down to row 4, confirm; hold cfg_ready=0
//    for 10 cycles -> cfg_valid=1 and cfg_word=8'b10_01_11_00 stable; assert ready
//    -> next cycle cfg_valid=0, run_en=1, state=3.
//  4 Re-commit: in SIG_RUN change amp to 3 -> cfg_word unchanged. Apply -> run_en stays 1
//    throughout, new cfg_word=8'b10_11_11_00.
//  5 Simultaneous: quit+confirm in same cycle in SIG_EDIT -> TOP, no cfg_valid.
//    left+right -> left only.
//  6 Quit during SIG_WAIT with cfg_ready=1 same cycle -> TOP, run_en=0, shadow_cfg=0.

Source files
------------

// File: rtl/sig_cfg_ctrl.sv
// Menu/configuration controller for the signal-generator path: walks the TOP/SIG/OSI/LoA menu,
// edits a shadow {wave,amp,fre,phase} config and commits it over a valid/ready handshake.
module sig_cfg_ctrl #(
  parameter int N_TOP     = 3,
  parameter int N_ROWS    = 5,
  parameter int FIELD_MAX = 3
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  input  logic       btn_quit,
  input  logic       cfg_ready,
  output logic [2:0] menu_state,
  output logic       level,
  output logic [1:0] top_sel,
  output logic [2:0] row_sel,
  output logic [7:0] shadow_cfg,
  output logic       cfg_valid,
  output logic [7:0] cfg_word,
  output logic       run_en
);

  typedef enum logic [2:0] {
    S_TOP      = 3'd0,
    S_SIG_EDIT = 3'd1,
    S_SIG_WAIT = 3'd2,
    S_SIG_RUN  = 3'd3,
    S_OSI      = 3'd4,
    S_LOA      = 3'd5
  } state_t;

  localparam logic [1:0] TOP_LAST  = 2'(N_TOP - 1);
  localparam logic [2:0] ROW_LAST  = 3'(N_ROWS - 1);
  localparam logic [1:0] FIELD_TOP = 2'(FIELD_MAX);

  state_t          state, state_nxt;
  logic [1:0]      top_nxt;
  logic [2:0]      row_nxt;
  logic [3:0][1:0] shadow, shadow_nxt;
  logic            valid_nxt, run_nxt;
  logic [7:0]      word_nxt;
  logic [1:0]      fld_idx;

  function automatic logic [1:0] field_inc(input logic [1:0] v);
    return (v >= FIELD_TOP) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [1:0] field_dec(input logic [1:0] v);
    return (v == 2'd0) ? FIELD_TOP : v - 2'd1;
  endfunction

  // Row 0 (wave) lives in the most significant field of the packed shadow word.
  assign fld_idx = 2'd3 - row_sel[1:0];

  always_comb begin
    state_nxt  = state;
    top_nxt    = top_sel;
    row_nxt    = row_sel;
    shadow_nxt = shadow;
    valid_nxt  = cfg_valid;
    run_nxt    = run_en;
    word_nxt   = cfg_word;

    if (btn_quit && state != S_TOP) begin
      state_nxt  = S_TOP;
      top_nxt    = 2'd0;
      row_nxt    = 3'd0;
      shadow_nxt = '0;
      valid_nxt  = 1'b0;
      run_nxt    = 1'b0;
    end else begin
      case (state)
        S_TOP: begin
          if (!btn_quit) begin
            if (btn_confirm) begin
              case (top_sel)
                2'd0:    state_nxt = S_SIG_EDIT;
                2'd1:    state_nxt = S_OSI;
                2'd2:    state_nxt = S_LOA;
                default: state_nxt = S_TOP;
              endcase
            end else if (!(btn_up || btn_down)) begin
              if (btn_left)
                top_nxt = (top_sel == 2'd0) ? TOP_LAST : top_sel - 2'd1;
              else if (btn_right)
                top_nxt = (top_sel >= TOP_LAST) ? 2'd0 : top_sel + 2'd1;
            end
          end
        end
        S_SIG_EDIT, S_SIG_RUN: begin
          if (btn_confirm) begin
            if (row_sel == ROW_LAST) begin
              state_nxt = S_SIG_WAIT;
              valid_nxt = 1'b1;
              word_nxt  = shadow;
            end
          end else if (btn_up) begin
            row_nxt = (row_sel == 3'd0) ? ROW_LAST : row_sel - 3'd1;
          end else if (btn_down) begin
            row_nxt = (row_sel >= ROW_LAST) ? 3'd0 : row_sel + 3'd1;
          end else if (row_sel != ROW_LAST) begin
            if (btn_left)
              shadow_nxt[fld_idx] = field_dec(shadow[fld_idx]);
            else if (btn_right)
              shadow_nxt[fld_idx] = field_inc(shadow[fld_idx]);
          end
        end
        S_SIG_WAIT: begin
          // run_en is left untouched so a previously committed config keeps running.
          if (cfg_valid && cfg_ready) begin
            state_nxt = S_SIG_RUN;
            valid_nxt = 1'b0;
            run_nxt   = 1'b1;
          end
        end
        S_OSI, S_LOA: ;
        default: state_nxt = S_TOP;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_TOP;
      level     <= 1'b0;
      top_sel   <= 2'd0;
      row_sel   <= 3'd0;
      shadow    <= '0;
      cfg_valid <= 1'b0;
      cfg_word  <= 8'd0;
      run_en    <= 1'b0;
    end else begin
      state     <= state_nxt;
      level     <= (state_nxt != S_TOP);
      top_sel   <= top_nxt;
      row_sel   <= row_nxt;
      shadow    <= shadow_nxt;
      cfg_valid <= valid_nxt;
      cfg_word  <= word_nxt;
      run_en    <= run_nxt;
    end
  end

  assign menu_state = state;
  assign shadow_cfg = shadow;

endmodule
